reg_file_sb: RTL and testbench

- Parametrised successor to the core's 32x32 register file: 2 read ports, 1 write port, configurable width and depth.
- Adds true async reset of all registers, a hardwired-zero x0 on every path, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode/issue (read, alloc) and writeback (write) in the pipelined RV32 datapath.

---
 rtl/reg_file_sb.sv | 116 +++++++++++
 tb/tb_reg_file_sb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file with hardwired-zero x0, async reset, optional
// same-cycle writeback bypass and a per-register busy scoreboard.

module rf_rd_port #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                        rst,
    input  logic [AW-1:0]               rs,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            busy,
    input  logic                        wr_vld,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    output logic [XLEN-1:0]             data,
    output logic                        busy_o
);
    logic hit;

    always_comb begin
        hit    = BYPASS && wr_vld && (wr_addr == rs);
        data   = '0;
        busy_o = 1'b0;
        // x0 and reset force zero on every path, bypass included
        if (!rst && rs != '0) begin
            data   = hit ? wr_data : regs[rs];
            busy_o = hit ? 1'b0 : busy[rs];
        end
    end
endmodule

module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    output logic            busy1,
    output logic            busy2,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rd,
    output logic            any_busy
);
    localparam int NRP = 2;

    typedef struct packed {
        logic            vld;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
    } alloc_req_t;

    wr_req_t                    wr;
    alloc_req_t                 al;
    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0]           busy_q;
    logic [NRP-1:0][AW-1:0]     rs_v;
    logic [NRP-1:0][XLEN-1:0]   out_v;
    logic [NRP-1:0]             busy_v;

    assign wr = '{vld: reg_write && (rd != '0), addr: rd, data: write_data};
    assign al = '{vld: alloc_en && (alloc_rd != '0), addr: alloc_rd};

    // Entry 0 is only ever written by reset, so it stays a constant zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr.vld && wr.addr == AW'(i))
                    regs_q[i] <= wr.data;
                // set after clear: a newly issued producer outranks the returning result
                busy_q[i] <= (busy_q[i] & ~(wr.vld && wr.addr == AW'(i)))
                           | (al.vld && al.addr == AW'(i));
            end
        end
    end

    assign rs_v = {rs2, rs1};

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        rf_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS), .AW(AW)) u_rd (
            .rst     (rst),
            .rs      (rs_v[p]),
            .regs    (regs_q),
            .busy    (busy_q),
            .wr_vld  (wr.vld),
            .wr_addr (wr.addr),
            .wr_data (wr.data),
            .data    (out_v[p]),
            .busy_o  (busy_v[p])
        );
    end

    assign out1     = out_v[0];
    assign out2     = out_v[1];
    assign busy1    = busy_v[0];
    assign busy2    = busy_v[1];
    assign any_busy = |busy_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised + directed bench: three configurations against an array model.

module tb_reg_file_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  rs1, rs2, rd, alloc_rd;
    logic        reg_write, alloc_en;
    logic [31:0] write_data;
    logic [3:0]  rs1b, rs2b, rdb, ardb;
    logic        web, alb;
    logic [63:0] wdb;

    logic [31:0] a_o1, a_o2, b_o1, b_o2;
    logic        a_b1, a_b2, a_any, b_b1, b_b2, b_any;
    logic [63:0] c_o1, c_o2;
    logic        c_b1, c_b2, c_any;

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .out1(a_o1), .out2(a_o2),
        .busy1(a_b1), .busy2(a_b2), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .alloc_en(alloc_en), .alloc_rd(alloc_rd), .any_busy(a_any));

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .out1(b_o1), .out2(b_o2),
        .busy1(b_b1), .busy2(b_b2), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .alloc_en(alloc_en), .alloc_rd(alloc_rd), .any_busy(b_any));

    reg_file_sb #(.XLEN(64), .NREGS(16), .BYPASS(1'b1)) dut_e (
        .clk(clk), .rst(rst), .rs1(rs1b), .rs2(rs2b), .out1(c_o1), .out2(c_o2),
        .busy1(c_b1), .busy2(c_b2), .reg_write(web), .rd(rdb),
        .write_data(wdb), .alloc_en(alb), .alloc_rd(ardb), .any_busy(c_any));

    // architectural model: register contents and pending-write flags
    logic [31:0] mreg [32];
    bit          mbsy [32];
    logic [63:0] mreg2 [16];
    bit          mbsy2 [16];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clr_model();
        for (int i = 0; i < 32; i++) begin mreg[i] = '0; mbsy[i] = 0; end
        for (int i = 0; i < 16; i++) begin mreg2[i] = '0; mbsy2[i] = 0; end
    endfunction

    function automatic logic [31:0] e_out(bit bp, logic [4:0] rs);
        if (rst || rs == 0) return '0;
        if (bp && reg_write && rd == rs) return write_data;
        return mreg[rs];
    endfunction

    function automatic bit e_bsy(bit bp, logic [4:0] rs);
        if (rst || rs == 0) return 0;
        if (bp && reg_write && rd == rs) return 0;
        return mbsy[rs];
    endfunction

    function automatic logic [63:0] e_out2(logic [3:0] rs);
        if (rst || rs == 0) return '0;
        if (web && rdb == rs) return wdb;
        return mreg2[rs];
    endfunction

    function automatic bit e_bsy2(logic [3:0] rs);
        if (rst || rs == 0) return 0;
        if (web && rdb == rs) return 0;
        return mbsy2[rs];
    endfunction

    function automatic bit e_any();
        bit r = 0;
        for (int i = 0; i < 32; i++) r |= mbsy[i];
        return r;
    endfunction

    function automatic bit e_any2();
        bit r = 0;
        for (int i = 0; i < 16; i++) r |= mbsy2[i];
        return r;
    endfunction

    // Inputs are set just after a negedge; check combinational outputs
    // mid-cycle, then advance the model on the posedge.
    task automatic cyc();
        #1;
        if (rst) clr_model();
        chk("bp_out1", a_o1, e_out(1, rs1));
        chk("bp_out2", a_o2, e_out(1, rs2));
        chk("bp_busy1", a_b1, e_bsy(1, rs1));
        chk("bp_busy2", a_b2, e_bsy(1, rs2));
        chk("bp_any", a_any, e_any());
        chk("nb_out1", b_o1, e_out(0, rs1));
        chk("nb_out2", b_o2, e_out(0, rs2));
        chk("nb_busy1", b_b1, e_bsy(0, rs1));
        chk("nb_busy2", b_b2, e_bsy(0, rs2));
        chk("nb_any", b_any, e_any());
        chk("e_out1", c_o1, e_out2(rs1b));
        chk("e_out2", c_o2, e_out2(rs2b));
        chk("e_busy1", c_b1, e_bsy2(rs1b));
        chk("e_busy2", c_b2, e_bsy2(rs2b));
        chk("e_any", c_any, e_any2());
        @(posedge clk);
        if (!rst) begin
            if (reg_write && rd != 0) begin mreg[rd] = write_data; mbsy[rd] = 0; end
            if (alloc_en && alloc_rd != 0) mbsy[alloc_rd] = 1;
            if (web && rdb != 0) begin mreg2[rdb] = wdb; mbsy2[rdb] = 0; end
            if (alb && ardb != 0) mbsy2[ardb] = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reg_write = 0; alloc_en = 0; web = 0; alb = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1; rd = a; write_data = d;
    endtask

    task automatic al(input logic [4:0] a);
        alloc_en = 1; alloc_rd = a;
    endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0; rd = 0; alloc_rd = 0; write_data = 0;
        rs1b = 0; rs2b = 0; rdb = 0; ardb = 0; wdb = 0;
        idle();
        clr_model();
        @(negedge clk);
        cyc();
        rst = 0;
        cyc();

        // reset clear: populate x5, mark x6 busy, then pulse reset mid-cycle
        wr(5, 32'hDEADBEEF); al(6); rs1 = 5; rs2 = 6;
        cyc();
        idle();
        cyc();
        chk("pre_rst_x5", a_o1, 32'hDEADBEEF);
        rst = 1;
        cyc();
        chk("rst_out1", a_o1, 32'h0);
        chk("rst_any", a_any, 1'b0);
        rst = 0;
        cyc();

        // x0 protection
        wr(0, 32'h12345678); al(0); rs1 = 0; rs2 = 0;
        cyc();
        idle();
        cyc();

        // write/read and bypass on x3
        wr(3, 32'h7); rs1 = 3; rs2 = 3;
        cyc();
        idle();
        cyc();

        // scoreboard lifecycle on x10
        al(10); rs1 = 10; rs2 = 10;
        cyc();
        idle();
        cyc();
        wr(10, 32'hA5A5A5A5);
        cyc();
        idle();
        cyc();

        // alloc + write same register, then different registers
        wr(7, 32'h0BAD_F00D); al(7); rs1 = 7; rs2 = 9;
        cyc();
        idle(); al(9);
        cyc();
        idle(); wr(9, 32'h99); al(8); rs1 = 8; rs2 = 9;
        cyc();
        idle();
        cyc();
        // double alloc then single write clears
        al(12); rs1 = 12;
        cyc();
        al(12);
        cyc();
        idle(); wr(12, 32'h1);
        cyc();
        idle();
        cyc();

        // 16x64 instance: x15 on both ports, x0 still zero
        web = 1; rdb = 15; wdb = 64'hFFFF_0000_FFFF_0000; rs1b = 15; rs2b = 15;
        cyc();
        web = 0;
        cyc();
        rs2b = 0;
        cyc();

        // reset while a write and alloc are in flight on the same edge
        wr(4, 32'h44); al(4); web = 1; rdb = 2; alb = 1; ardb = 2; rst = 1;
        rs1 = 4; rs1b = 2;
        cyc();
        idle(); rst = 0;
        cyc();

        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            rs1       = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 7));
            reg_write = 1'($urandom_range(0, 1));
            rd        = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            write_data = $urandom();
            alloc_en  = 1'($urandom_range(0, 1));
            alloc_rd  = 5'($urandom_range(0, 7));
            rs1b      = 4'($urandom_range(0, 15));
            rs2b      = 4'($urandom_range(0, 5));
            web       = 1'($urandom_range(0, 1));
            rdb       = 4'($urandom_range(0, 5));
            wdb       = {$urandom(), $urandom()};
            alb       = 1'($urandom_range(0, 1));
            ardb      = 4'($urandom_range(0, 5));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
